// File: rtl/pls_reg_group_bank_if.sv
// Register-group bus between the pulse configurator (master) and a register bank (slave).
// A request is held until ack; rdata and err are valid only while ack is high.
interface pls_reg_group_bank_if #(
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 32
);
  logic                 req;
  logic                 we;
  logic [ADDR_SIZE-1:0] addr;
  logic [DATA_SIZE-1:0] wdata;
  logic [DATA_SIZE-1:0] rdata;
  logic                 ack;
  logic                 err;

  modport master (output req, we, addr, wdata, input rdata, ack, err);
  modport slave  (input req, we, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/pls_reg_group_bank.sv
// Ping-pong parameter banks for the signal generator: bank 0 is written through g1, bank 1 through g2.
// The active bank only swaps at a generator sync strobe, so the core never reads a half-written set.
module pls_reg_group_bank #(
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 32
) (
  input  logic                 aclk,
  input  logic                 areset,
  pls_reg_group_bank_if.slave  g1,
  pls_reg_group_bank_if.slave  g2,
  input  logic                 group_select,
  input  logic                 sync_strobe,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 active_group,
  output logic                 switch_pending,
  output logic                 switched
);

  localparam int DEPTH = 2 ** ADDR_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESP,
    ST_RELEASE
  } port_state_t;

  port_state_t          r_state  [2];
  logic                 r_we     [2];
  logic [ADDR_SIZE-1:0] r_addr   [2];
  logic [DATA_SIZE-1:0] r_wdata  [2];
  logic [DATA_SIZE-1:0] r_rdata  [2];
  logic [DATA_SIZE-1:0] r_bank   [2][DEPTH];
  logic [DATA_SIZE-1:0] r_rd_data;
  logic                 r_active;
  logic                 r_switched;

  logic                 w_req    [2];
  logic                 w_we     [2];
  logic [ADDR_SIZE-1:0] w_addr   [2];
  logic [DATA_SIZE-1:0] w_wdata  [2];
  logic                 w_resp   [2];
  logic                 w_err    [2];
  logic                 w_pending;
  logic                 w_blocked;

  assign w_req[0]   = g1.req;
  assign w_we[0]    = g1.we;
  assign w_addr[0]  = g1.addr;
  assign w_wdata[0] = g1.wdata;
  assign w_req[1]   = g2.req;
  assign w_we[1]    = g2.we;
  assign w_addr[1]  = g2.addr;
  assign w_wdata[1] = g2.wdata;

  assign w_resp[0] = (r_state[0] == ST_RESP);
  assign w_resp[1] = (r_state[1] == ST_RESP);

  // A write is refused when its bank is the one the generator is currently reading.
  assign w_err[0] = w_resp[0] & r_we[0] & ~r_active;
  assign w_err[1] = w_resp[1] & r_we[1] & r_active;

  assign g1.ack   = w_resp[0];
  assign g1.err   = w_err[0];
  assign g1.rdata = r_rdata[0];
  assign g2.ack   = w_resp[1];
  assign g2.err   = w_err[1];
  assign g2.rdata = r_rdata[1];

  assign w_pending = (group_select != r_active);
  assign w_blocked = group_select ? w_resp[1] : w_resp[0];

  assign rd_data        = r_rd_data;
  assign active_group   = r_active;
  assign switch_pending = w_pending;
  assign switched       = r_switched;

  // Read data is captured on accept; the owning port is the only writer of its bank, so it
  // still matches the bank contents during the response cycle.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int p = 0; p < 2; p++) begin
        r_state[p] <= ST_IDLE;
        r_we[p]    <= 1'b0;
        r_addr[p]  <= '0;
        r_wdata[p] <= '0;
        r_rdata[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        case (r_state[p])
          ST_IDLE: begin
            if (w_req[p]) begin
              r_we[p]    <= w_we[p];
              r_addr[p]  <= w_addr[p];
              r_wdata[p] <= w_wdata[p];
              r_rdata[p] <= r_bank[p][w_addr[p]];
              r_state[p] <= ST_RESP;
            end
          end
          ST_RESP:    r_state[p] <= ST_RELEASE;
          ST_RELEASE: if (!w_req[p]) r_state[p] <= ST_IDLE;
          default:    r_state[p] <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int p = 0; p < 2; p++) begin
        for (int a = 0; a < DEPTH; a++) begin
          r_bank[p][a] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (w_resp[p] && r_we[p] && (r_active != p[0])) begin
          r_bank[p][r_addr[p]] <= r_wdata[p];
        end
      end
    end
  end

  // The swap is held off while the incoming bank's owner is mid-response, so its write lands first.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rd_data  <= '0;
      r_active   <= 1'b0;
      r_switched <= 1'b0;
    end else begin
      r_rd_data <= r_bank[r_active][rd_addr];
      if (sync_strobe && w_pending && !w_blocked) begin
        r_active   <= group_select;
        r_switched <= 1'b1;
      end else begin
        r_switched <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pls_reg_group_bank.sv
// Bench for pls_reg_group_bank: directed transaction table, corner sequences, then random traffic
// compared every cycle against a transaction-level model of the two banks and the swap rule.
module tb_pls_reg_group_bank;

  logic        aclk = 1'b0;
  logic        areset;
  logic        pReq   [2];
  logic        pWe    [2];
  logic [3:0]  pAddr  [2];
  logic [31:0] pWdata [2];
  logic        groupSelect;
  logic        syncStrobe;
  logic [3:0]  rdAddr;
  logic [31:0] rdData;
  logic        activeGroup;
  logic        switchPending;
  logic        switched;

  int total = 0;
  int bad   = 0;

  logic [31:0] mBank [2][16];
  bit          mActive;
  bit          mSwitched;
  logic [31:0] mRd;
  bit          mAck   [2];
  bit          mWait  [2];
  bit          mWe    [2];
  logic [3:0]  mAddr  [2];
  logic [31:0] mWdata [2];
  logic [31:0] mRdata [2];

  typedef struct {
    int          port;
    bit          we;
    logic [3:0]  addr;
    logic [31:0] data;
    bit          expErr;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs [8];

  pls_reg_group_bank_if #(.ADDR_SIZE(4), .DATA_SIZE(32)) g1Bus ();
  pls_reg_group_bank_if #(.ADDR_SIZE(4), .DATA_SIZE(32)) g2Bus ();

  assign g1Bus.req   = pReq[0];
  assign g1Bus.we    = pWe[0];
  assign g1Bus.addr  = pAddr[0];
  assign g1Bus.wdata = pWdata[0];
  assign g2Bus.req   = pReq[1];
  assign g2Bus.we    = pWe[1];
  assign g2Bus.addr  = pAddr[1];
  assign g2Bus.wdata = pWdata[1];

  pls_reg_group_bank #(.ADDR_SIZE(4), .DATA_SIZE(32)) dut (
    .aclk           (aclk),
    .areset         (areset),
    .g1             (g1Bus),
    .g2             (g2Bus),
    .group_select   (groupSelect),
    .sync_strobe    (syncStrobe),
    .rd_addr        (rdAddr),
    .rd_data        (rdData),
    .active_group   (activeGroup),
    .switch_pending (switchPending),
    .switched       (switched)
  );

  always #5 aclk = ~aclk;

  function automatic logic portAck(int i);
    return (i == 0) ? g1Bus.ack : g2Bus.ack;
  endfunction

  function automatic logic portErr(int i);
    return (i == 0) ? g1Bus.err : g2Bus.err;
  endfunction

  function automatic logic [31:0] portRdata(int i);
    return (i == 0) ? g1Bus.rdata : g2Bus.rdata;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < 16; a++) mBank[p][a] = '0;
      mAck[p]   = 0;
      mWait[p]  = 0;
      mWe[p]    = 0;
      mAddr[p]  = '0;
      mWdata[p] = '0;
      mRdata[p] = '0;
    end
    mActive   = 0;
    mSwitched = 0;
    mRd       = '0;
  endtask

  // Advance the model across one clock edge using the inputs that were stable before it.
  task automatic modelEdge();
    logic [31:0] newRd;
    bit          blocked;
    newRd   = mBank[mActive][rdAddr];
    blocked = mAck[groupSelect];
    for (int p = 0; p < 2; p++) begin
      if (mAck[p]) begin
        if (mWe[p] && (p != int'(mActive))) mBank[p][mAddr[p]] = mWdata[p];
        mAck[p]  = 0;
        mWait[p] = 1;
      end else if (mWait[p]) begin
        if (!pReq[p]) mWait[p] = 0;
      end else if (pReq[p]) begin
        mWe[p]    = pWe[p];
        mAddr[p]  = pAddr[p];
        mWdata[p] = pWdata[p];
        mRdata[p] = mBank[p][pAddr[p]];
        mAck[p]   = 1;
      end
    end
    if (syncStrobe && (groupSelect != mActive) && !blocked) begin
      mActive   = groupSelect;
      mSwitched = 1;
    end else begin
      mSwitched = 0;
    end
    mRd = newRd;
  endtask

  task automatic compareAll();
    for (int p = 0; p < 2; p++) begin
      checkOutput($sformatf("g%0dAck", p + 1), 32'(portAck(p)), 32'(mAck[p]));
      checkOutput($sformatf("g%0dErr", p + 1), 32'(portErr(p)),
                  32'(mAck[p] && mWe[p] && (p == int'(mActive))));
      if (mAck[p] && !mWe[p])
        checkOutput($sformatf("g%0dRdata", p + 1), portRdata(p), mRdata[p]);
    end
    checkOutput("rdData", rdData, mRd);
    checkOutput("activeGroup", 32'(activeGroup), 32'(mActive));
    checkOutput("switchPending", 32'(switchPending), 32'(groupSelect != mActive));
    checkOutput("switched", 32'(switched), 32'(mSwitched));
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
    if (areset) modelReset();
    else modelEdge();
    compareAll();
  endtask

  task automatic applyStimulus(input vec_t v);
    int i;
    i = v.port - 1;
    pReq[i]   = 1'b1;
    pWe[i]    = v.we;
    pAddr[i]  = v.addr;
    pWdata[i] = v.data;
    step();
    checkOutput("vecAck", 32'(portAck(i)), 32'd1);
    checkOutput("vecErr", 32'(portErr(i)), 32'(v.expErr));
    if (!v.we) checkOutput("vecRdata", portRdata(i), v.expRdata);
    pReq[i] = 1'b0;
    step();
    step();
  endtask

  initial begin
    int          ackCount;
    bit          acked [2];
    int          coolDown [2];

    vecs[0] = '{1, 1'b1, 4'd3,  32'h40490FDB, 1'b1, 32'h0};
    vecs[1] = '{1, 1'b0, 4'd3,  32'h0,        1'b0, 32'h0};
    vecs[2] = '{2, 1'b1, 4'd3,  32'h3F800000, 1'b0, 32'h0};
    vecs[3] = '{2, 1'b0, 4'd3,  32'h0,        1'b0, 32'h3F800000};
    vecs[4] = '{2, 1'b1, 4'd15, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[5] = '{2, 1'b0, 4'd15, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[6] = '{1, 1'b0, 4'd15, 32'h0,        1'b0, 32'h0};
    vecs[7] = '{2, 1'b0, 4'd0,  32'h0,        1'b0, 32'h0};

    for (int p = 0; p < 2; p++) begin
      pReq[p]   = 1'b0;
      pWe[p]    = 1'b0;
      pAddr[p]  = '0;
      pWdata[p] = '0;
    end
    groupSelect = 1'b0;
    syncStrobe  = 1'b0;
    rdAddr      = '0;
    areset      = 1'b1;
    #1;
    modelReset();
    compareAll();
    checkOutput("resetRdata1", g1Bus.rdata, 32'h0);
    checkOutput("resetRdata2", g2Bus.rdata, 32'h0);
    step();
    step();
    areset = 1'b0;

    $display("[TB] directed transaction table");
    foreach (vecs[k]) applyStimulus(vecs[k]);

    rdAddr = 4'd3;
    step();
    step();
    checkOutput("inactiveWriteHidden", rdData, 32'h0);
    groupSelect = 1'b1;
    syncStrobe  = 1'b1;
    step();
    syncStrobe = 1'b0;
    checkOutput("swapActive", 32'(activeGroup), 32'd1);
    checkOutput("swapPulse", 32'(switched), 32'd1);
    step();
    checkOutput("swapRdData", rdData, 32'h3F800000);
    checkOutput("swapPulseEnd", 32'(switched), 32'd0);

    $display("[TB] long pending without strobe, then withdrawn request");
    groupSelect = 1'b0;
    for (int c = 0; c < 100; c++) step();
    checkOutput("noStrobeActive", 32'(activeGroup), 32'd1);
    checkOutput("noStrobePending", 32'(switchPending), 32'd1);
    groupSelect = 1'b1;
    step();
    checkOutput("withdrawnPending", 32'(switchPending), 32'd0);
    syncStrobe = 1'b1;
    step();
    syncStrobe = 1'b0;
    checkOutput("withdrawnActive", 32'(activeGroup), 32'd1);
    checkOutput("withdrawnSwitched", 32'(switched), 32'd0);

    $display("[TB] swap deferred by incoming bank owner in response");
    groupSelect = 1'b0;
    syncStrobe  = 1'b1;
    step();
    syncStrobe = 1'b0;
    checkOutput("backToBank0", 32'(activeGroup), 32'd0);
    groupSelect = 1'b1;
    pReq[1]   = 1'b1;
    pWe[1]    = 1'b1;
    pAddr[1]  = 4'd7;
    pWdata[1] = 32'h11223344;
    step();
    checkOutput("deferAck", 32'(g2Bus.ack), 32'd1);
    checkOutput("deferErr", 32'(g2Bus.err), 32'd0);
    syncStrobe = 1'b1;
    pReq[1]    = 1'b0;
    step();
    syncStrobe = 1'b0;
    checkOutput("deferActive", 32'(activeGroup), 32'd0);
    checkOutput("deferPending", 32'(switchPending), 32'd1);
    step();
    syncStrobe = 1'b1;
    step();
    syncStrobe = 1'b0;
    checkOutput("deferLaterActive", 32'(activeGroup), 32'd1);
    checkOutput("deferLaterPulse", 32'(switched), 32'd1);
    rdAddr = 4'd7;
    step();
    checkOutput("deferRdData", rdData, 32'h11223344);

    $display("[TB] held request yields a single ack");
    pReq[0]  = 1'b1;
    pWe[0]   = 1'b0;
    pAddr[0] = 4'd3;
    ackCount = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (g1Bus.ack === 1'b1) ackCount++;
    end
    checkOutput("heldAckCount", 32'(ackCount), 32'd1);
    pReq[0] = 1'b0;
    step();
    pReq[0] = 1'b1;
    step();
    checkOutput("reassertAck", 32'(g1Bus.ack), 32'd1);
    pReq[0] = 1'b0;
    step();
    step();

    $display("[TB] reset during a write response");
    pReq[0]   = 1'b1;
    pWe[0]    = 1'b1;
    pAddr[0]  = 4'd5;
    pWdata[0] = 32'hA5A5A5A5;
    step();
    checkOutput("preResetAck", 32'(g1Bus.ack), 32'd1);
    checkOutput("preResetErr", 32'(g1Bus.err), 32'd0);
    areset = 1'b1;
    #1;
    checkOutput("asyncAck", 32'(g1Bus.ack), 32'd0);
    checkOutput("asyncActive", 32'(activeGroup), 32'd0);
    checkOutput("asyncRdData", rdData, 32'h0);
    checkOutput("asyncRdata1", g1Bus.rdata, 32'h0);
    checkOutput("asyncSwitched", 32'(switched), 32'd0);
    modelReset();
    pReq[0]     = 1'b0;
    groupSelect = 1'b0;
    step();
    areset = 1'b0;
    applyStimulus('{1, 1'b0, 4'd5, 32'h0, 1'b0, 32'h0});
    applyStimulus('{2, 1'b0, 4'd7, 32'h0, 1'b0, 32'h0});

    $display("[TB] random traffic against model");
    for (int p = 0; p < 2; p++) begin
      acked[p]    = 0;
      coolDown[p] = 0;
    end
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pReq[p]) begin
          if (coolDown[p] > 0) coolDown[p]--;
          else if ($urandom_range(2) == 0) begin
            pReq[p]   = 1'b1;
            pWe[p]    = 1'($urandom_range(1));
            pAddr[p]  = 4'($urandom_range(15));
            pWdata[p] = $urandom;
          end
        end else if (acked[p] && ($urandom_range(1) == 0)) begin
          pReq[p]     = 1'b0;
          acked[p]    = 0;
          coolDown[p] = 2;
        end
      end
      if ($urandom_range(7) == 0) groupSelect = ~groupSelect;
      syncStrobe = ($urandom_range(3) == 0);
      rdAddr     = 4'($urandom_range(15));
      step();
      for (int p = 0; p < 2; p++) if (mAck[p]) acked[p] = 1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
